// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer: 32-step shift-add multiply / restoring divide on
// operand magnitudes, with sign fix-up and a one-cycle done pulse.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      alu_ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(ITERS) + 1;
  localparam logic [4:0] OP_MUL    = 5'b01110;
  localparam logic [4:0] OP_MULH   = 5'b01111;
  localparam logic [4:0] OP_MULHSU = 5'b10000;
  localparam logic [4:0] OP_MULHU  = 5'b10001;
  localparam logic [4:0] OP_DIV    = 5'b10010;
  localparam logic [4:0] OP_DIVU   = 5'b10011;
  localparam logic [4:0] OP_REM    = 5'b10100;
  localparam logic [4:0] OP_REMU   = 5'b10101;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4:0]            op_q, op_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]       opb_q, opb_d;
  logic [XLEN-1:0]       a_q, a_d;
  logic                  neg_q, neg_d, rneg_q, rneg_d;
  logic                  fast_q, fast_d, dz_q, dz_d;
  logic [XLEN-1:0]       result_q, result_d;

  logic            is_md, is_div, a_sgn, b_sgn, dz, ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0] mcand);
    logic [XLEN:0] sum;
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    return {sum, acc[XLEN-1:1]};
  endfunction

  function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0] dvsr);
    logic [XLEN:0] r, diff;
    logic          ge;
    r    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff = r - {1'b0, dvsr};
    ge   = ~diff[XLEN];
    return {(ge ? diff[XLEN-1:0] : r[XLEN-1:0]), acc[XLEN-2:0], ge};
  endfunction

  function automatic logic [XLEN-1:0] fix_result(input logic [4:0] op,
                                                 input logic [2*XLEN-1:0] acc,
                                                 input logic neg, input logic rneg,
                                                 input logic fast, input logic dzero,
                                                 input logic [XLEN-1:0] a);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    prod = neg ? -acc : acc;
    quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = rneg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      OP_MUL:                         return prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   return prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:                return fast ? (dzero ? '1 : MIN_NEG) : quo;
      default:                        return fast ? (dzero ? a : '0) : rem;
    endcase
  endfunction

  // Accept-time decode: operand signedness, magnitudes and fast-path detection.
  always_comb begin
    is_md  = (alu_ctrl >= OP_MUL) && (alu_ctrl <= OP_REMU);
    is_div = alu_ctrl >= OP_DIV;
    a_sgn  = (alu_ctrl == OP_MULH || alu_ctrl == OP_MULHSU ||
              alu_ctrl == OP_DIV  || alu_ctrl == OP_REM) && src_a[XLEN-1];
    b_sgn  = (alu_ctrl == OP_MULH || alu_ctrl == OP_DIV || alu_ctrl == OP_REM) &&
             src_b[XLEN-1];
    a_mag  = a_sgn ? -src_a : src_a;
    b_mag  = b_sgn ? -src_b : src_b;
    dz     = (src_b == '0);
    ovf    = (alu_ctrl == OP_DIV || alu_ctrl == OP_REM) &&
             (src_a == MIN_NEG) && (src_b == '1);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    a_d      = a_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    fast_d   = fast_q;
    dz_d     = dz_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start && is_md) begin
          op_d   = alu_ctrl;
          a_d    = src_a;
          cnt_d  = '0;
          neg_d  = a_sgn ^ b_sgn;
          rneg_d = a_sgn;
          acc_d  = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
          opb_d  = is_div ? b_mag : a_mag;
          fast_d = is_div && (dz || ovf);
          dz_d   = dz;
          state_d = (is_div && (dz || ovf)) ? FIX : CALC;
        end
      end
      CALC: begin
        acc_d = (op_q >= OP_DIV) ? div_step(acc_q, opb_q) : mul_step(acc_q, opb_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITERS - 1)) state_d = FIX;
      end
      FIX: begin
        result_d = fix_result(op_q, acc_q, neg_q, rneg_q, fast_q, dz_q, a_q);
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Datapath registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    acc_q  <= acc_d;
    opb_q  <= opb_d;
    a_q    <= a_d;
    neg_q  <= neg_d;
    rneg_q <= rneg_d;
    fast_q <= fast_d;
    dz_q   <= dz_d;
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign stall  = start && is_md && (state_q != DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected results queued at issue, compared
// when the done pulse appears, plus latency/stall/flush/reset scenarios.
module tb_muldiv_seq;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_MUL    = 5'b01110;
  localparam logic [4:0] OP_MULH   = 5'b01111;
  localparam logic [4:0] OP_MULHSU = 5'b10000;
  localparam logic [4:0] OP_MULHU  = 5'b10001;
  localparam logic [4:0] OP_DIV    = 5'b10010;
  localparam logic [4:0] OP_DIVU   = 5'b10011;
  localparam logic [4:0] OP_REM    = 5'b10100;
  localparam logic [4:0] OP_REMU   = 5'b10101;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [4:0]  alu_ctrl;
  logic [31:0] src_a, src_b;
  logic        busy, stall, done;
  logic [31:0] result;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_done_cyc = 0;
  logic [31:0] last_exp = 32'h0;
  logic [31:0] sb_q[$];

  muldiv_seq #(.XLEN(32), .ITERS(32)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_ctrl(alu_ctrl),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [4:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    logic        ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    za  = {32'h0, a};
    zb  = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'h0;
    case (c)
      OP_MUL:    begin p = za * zb; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * zb; return p[63:32]; end
      OP_MULHU:  begin p = za * zb; return p[63:32]; end
      OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op at a negedge, wait for accept, then for done; checks stall,
  // latency (posedges after the accept edge), result and single-cycle pulse.
  task automatic run_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input bit scramble,
                        input bit hold, input string nm);
    int          k;
    bit          seen, stall_ok;
    logic [31:0] e;
    start = 1'b1; alu_ctrl = code; src_a = a; src_b = b;
    sb_q.push_back(exp);
    #1;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (!busy) begin
        checks++;
        if (stall !== 1'b1) begin
          failures++; $display("FAIL %s accept_stall: got %b want 1", nm, stall);
        end
      end
      @(negedge clk); #1;
      if (busy) seen = 1'b1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s accept: busy never rose (got 0 want 1)", nm);
      void'(sb_q.pop_back());
      start = 1'b0;
      return;
    end
    k = 0; stall_ok = 1'b1;
    while (!done && k < 40) begin
      if (stall !== 1'b1) stall_ok = 1'b0;
      if (scramble) begin src_a = $urandom; src_b = $urandom; end
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (!stall_ok) begin failures++; $display("FAIL %s busy_stall: got 0 want 1", nm); end
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL %s done_timeout: got %b want 1", nm, done);
    end
    checks++;
    if (k != lat) begin failures++; $display("FAIL %s latency: got %0d want %0d", nm, k, lat); end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL %s done_stall: got %b want 0", nm, stall); end
    e = sb_q.pop_front();
    checks++;
    if (result !== e) begin
      failures++; $display("FAIL %s result: got %h want %h", nm, result, e);
    end
    last_exp = e;
    last_done_cyc = cyc;
    if (!hold) begin
      start = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL %s pulse_width: got %b want 0", nm, done); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; alu_ctrl = OP_ADD; src_a = 0; src_b = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)    begin failures++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL rst_result: got %h want 0", result); end
    checks++; if (stall !== 1'b0)   begin failures++; $display("FAIL rst_stall: got %b want 0", stall); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_calc();
    start = 1'b1; alu_ctrl = OP_MUL; src_a = 32'd5; src_b = 32'd6;
    repeat (10) @(negedge clk);
    reset = 1'b1; start = 1'b0;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)    begin failures++; $display("FAIL midrst_done: got %b want 0", done); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL midrst_result: got %h want 0", result); end
    reset = 1'b0;
    @(negedge clk);
    run_op(OP_MUL, 32'd3, 32'd4, 32'h0000_000C, 33, 1'b0, 1'b0, "mul_after_rst");
  endtask

  task automatic test_mul();
    logic [31:0] a, b;
    run_op(OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0, 1'b0, "mul");
    run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0, 1'b0, "mulh");
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0, 1'b0, "mulhu");
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0, 1'b0, "mulhsu");
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      run_op(OP_MUL + 5'(i), a, b, model(OP_MUL + 5'(i), a, b), 33, 1'b1, 1'b0, "mul_rand");
    end
  endtask

  task automatic test_div();
    logic [31:0] a, b;
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0, 1'b0, "div");
    run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0, 1'b0, "rem");
    run_op(OP_DIVU, 32'd100,       32'd7, 32'd14,        33, 1'b0, 1'b0, "divu");
    run_op(OP_REMU, 32'd100,       32'd7, 32'd2,         33, 1'b0, 1'b0, "remu");
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = ($urandom >> (i * 7)) | 32'h1;
      run_op(OP_DIV + 5'(i), a, b, model(OP_DIV + 5'(i), a, b), 33, 1'b1, 1'b0, "div_rand");
    end
  endtask

  task automatic test_fast();
    run_op(OP_DIV, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 1'b0, 1'b0, "div_by0");
    run_op(OP_REM, 32'd5,         32'd0,         32'd5,         1, 1'b0, 1'b0, "rem_by0");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, 1'b0, "div_ovf");
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, 1'b0, 1'b0, "rem_ovf");
  endtask

  task automatic test_flush();
    int ndone;
    start = 1'b1; alu_ctrl = OP_DIV; src_a = 32'd100; src_b = 32'd7;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL flush_done: got %b want 0", done); end
    checks++;
    if (result !== last_exp) begin
      failures++; $display("FAIL flush_result: got %h want %h", result, last_exp);
    end
    flush = 1'b0; start = 1'b0;
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done) ndone++; end
    checks++; if (ndone != 0) begin failures++; $display("FAIL flush_no_pulse: got %0d want 0", ndone); end
    start = 1'b1; flush = 1'b1; alu_ctrl = OP_MUL; src_a = 32'd2; src_b = 32'd3;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_start: got busy %b want 0", busy); end
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int d1, bad;
    run_op(OP_MUL,  32'd1234, 32'd5678, 32'd7006652, 33, 1'b1, 1'b1, "b2b_mul");
    d1 = last_done_cyc;
    run_op(OP_DIVU, 32'd1000, 32'd33,   32'd30,      33, 1'b1, 1'b1, "b2b_divu");
    checks++;
    if (last_done_cyc - d1 != 35) begin
      failures++; $display("FAIL b2b_gap: got %0d want 35", last_done_cyc - d1);
    end
    alu_ctrl = OP_ADD; src_a = 32'd1; src_b = 32'd2;
    #1;
    bad = 0;
    repeat (6) begin
      if (stall !== 1'b0) bad++;
      @(negedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL add_ignored: got %0d bad cycles want 0", bad); end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_reset_mid_calc();
    test_mul();
    test_div();
    test_fast();
    test_flush();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: got %0d want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
